// File: rtl/mem_dma_copier_pkg.sv
// mem_dma_pkg: shared types and constants for the mem_dma_copier block.
//   dma_state_t      - FSM state encoding of the copier
//   WORD_BYTES       - byte stride between consecutive 32-bit words
//   WB_NONE/WB_WORD  - byte-write-enable patterns for a read / full-word write
//   start_misaligned - alignment check applied to a start request
package mem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] WB_NONE    = 4'h0;
  localparam logic [3:0] WB_WORD    = 4'hF;

  // The source address only matters in copy mode, so a fill may start
  // from any src value.
  function automatic logic start_misaligned(input logic [1:0] src_lsb,
                                            input logic [1:0] dst_lsb,
                                            input logic       fill);
    return (dst_lsb != 2'b00) || (!fill && (src_lsb != 2'b00));
  endfunction

endpackage

// File: rtl/mem_dma_copier_if.sv
// interface_memory: single RAM port as seen by an initiator and a target.
//   enable_in - port enable (master -> RAM)
//   wb_in     - per-byte write enables; all zero means read (master -> RAM)
//   addr_in   - byte address, sampled by the RAM at posedge (master -> RAM)
//   data_in   - write data (master -> RAM)
//   data_out  - registered read data, valid one cycle after the read (RAM -> master)
interface interface_memory #(
  parameter int MEMORY_BUS_WIDTH = 32
) ();

  logic                        enable_in;
  logic [3:0]                  wb_in;
  logic [MEMORY_BUS_WIDTH-1:0] addr_in;
  logic [MEMORY_BUS_WIDTH-1:0] data_in;
  logic [MEMORY_BUS_WIDTH-1:0] data_out;

  modport MASTER (
    output enable_in,
    output wb_in,
    output addr_in,
    output data_in,
    input  data_out
  );

  modport SLAVE (
    input  enable_in,
    input  wb_in,
    input  addr_in,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/mem_dma_copier.sv
// mem_dma_copier: single-channel DMA engine that copies or fills a block of
// 32-bit words through one port of a dual-port RAM.
// Ports:
//   clock      - system clock, all logic on posedge
//   reset      - synchronous active-high reset
//   mem_if     - interface_memory.MASTER towards the RAM port
//   start_in   - 1-cycle start pulse, only honoured in IDLE
//   src_in     - source byte address (copy mode)
//   dst_in     - destination byte address
//   len_in     - transfer length in words
//   fill_in    - 0: copy src->dst, 1: write pattern_in to every dst word
//   pattern_in - fill value
//   busy_out   - high while a transfer is in progress (including the done cycle)
//   done_out   - 1-cycle completion pulse
//   err_out    - 1-cycle pulse when a start is rejected for misalignment
module mem_dma_copier
  import mem_dma_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int LEN_W            = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  interface_memory.MASTER             mem_if,
  input  logic                        start_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] src_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] dst_in,
  input  logic [LEN_W-1:0]            len_in,
  input  logic                        fill_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] pattern_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        err_out
);

  localparam logic [MEMORY_BUS_WIDTH-1:0] STRIDE = MEMORY_BUS_WIDTH'(WORD_BYTES);

  dma_state_t                  state_q, state_nxt;
  logic [MEMORY_BUS_WIDTH-1:0] src_q, dst_q, pattern_q;
  logic [LEN_W-1:0]            rem_q;
  logic                        fill_q;
  logic                        err_q;
  logic                        misaligned;
  logic                        accept;

  assign misaligned = start_misaligned(src_in[1:0], dst_in[1:0], fill_in);
  // A zero-length start is accepted too; it just goes straight to DONE.
  assign accept     = (state_q == IDLE) && start_in && !misaligned;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      pattern_q <= '0;
      rem_q     <= '0;
      fill_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      err_q   <= (state_q == IDLE) && start_in && misaligned;
      if (accept) begin
        src_q     <= src_in;
        dst_q     <= dst_in;
        pattern_q <= pattern_in;
        rem_q     <= len_in;
        fill_q    <= fill_in;
      end else if (state_q == WRITE) begin
        // Address arithmetic deliberately wraps modulo 2**MEMORY_BUS_WIDTH.
        src_q <= src_q + STRIDE;
        dst_q <= dst_q + STRIDE;
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt        = state_q;
    mem_if.enable_in = 1'b0;
    mem_if.wb_in     = WB_NONE;
    mem_if.addr_in   = '0;
    mem_if.data_in   = '0;

    unique case (state_q)
      IDLE: begin
        if (start_in && !misaligned) begin
          if (len_in == '0)  state_nxt = DONE;
          else if (fill_in)  state_nxt = WRITE;
          else               state_nxt = READ;
        end
      end
      READ: begin
        mem_if.enable_in = 1'b1;
        mem_if.addr_in   = src_q;
        state_nxt        = WRITE;
      end
      WRITE: begin
        mem_if.enable_in = 1'b1;
        mem_if.wb_in     = WB_WORD;
        mem_if.addr_in   = dst_q;
        // In copy mode the RAM's registered output holds the word read in
        // the preceding READ cycle.
        mem_if.data_in   = fill_q ? pattern_q : mem_if.data_out;
        if (rem_q == LEN_W'(1)) state_nxt = DONE;
        else if (fill_q)        state_nxt = WRITE;
        else                    state_nxt = READ;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy_out = (state_q != IDLE);
  assign done_out = (state_q == DONE);
  assign err_out  = err_q;

endmodule

// File: tb/tb_mem_dma_copier.sv
// Bench for mem_dma_copier against a behavioural 4 KiB RAM (address masked
// to 12 bits) and a word-array reference model of the expected contents.
module tb_mem_dma_copier;

  localparam int LEN_W = 16;
  localparam int WORDS = 1024;

  logic              clock = 1'b0;
  logic              reset;
  logic              start_in;
  logic [31:0]       src_in, dst_in, pattern_in;
  logic [LEN_W-1:0]  len_in;
  logic              fill_in;
  logic              busy_out, done_out, err_out;

  always #5 clock = ~clock;

  interface_memory #(.MEMORY_BUS_WIDTH(32)) mem_if ();

  mem_dma_copier #(.MEMORY_BUS_WIDTH(32), .LEN_W(LEN_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_if     (mem_if),
    .start_in   (start_in),
    .src_in     (src_in),
    .dst_in     (dst_in),
    .len_in     (len_in),
    .fill_in    (fill_in),
    .pattern_in (pattern_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .err_out    (err_out)
  );

  // RAM: port B is the DUT, a second bench-only write port loads contents.
  logic [31:0] ram   [WORDS];
  logic [31:0] model [WORDS];
  logic        pa_we;
  logic [9:0]  pa_idx;
  logic [31:0] pa_data;

  always @(posedge clock) begin
    if (pa_we) ram[pa_idx] <= pa_data;
    if (mem_if.enable_in) begin
      for (int b = 0; b < 4; b++)
        if (mem_if.wb_in[b]) ram[mem_if.addr_in[11:2]][8*b +: 8] <= mem_if.data_in[8*b +: 8];
    end
    mem_if.data_out <= ram[mem_if.addr_in[11:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    model[idx] = v;
    pa_we = 1'b1; pa_idx = 10'(idx); pa_data = v;
    @(negedge clock);
    pa_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < WORDS; i++)
      if (ram[i] !== model[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // Reference: strictly ascending word-by-word move or fill.
  task automatic model_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input logic fill, input logic [31:0] pat);
    for (int i = 0; i < len; i++) begin
      logic [31:0] w;
      w = fill ? pat : model[widx(src + 32'(4*i))];
      model[widx(dst + 32'(4*i))] = w;
    end
  endtask

  // Issues a start at the current negedge and watches until done.
  // inject_at > 0 pulses a second start (dst=0x400) on that cycle.
  task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input logic fill, input logic [31:0] pat,
                          input int inject_at);
    int cyc = 0, lat = -1, en = 0, wr = 0, gap = 0;
    int exp_lat;
    src_in = src; dst_in = dst; len_in = LEN_W'(len); fill_in = fill; pattern_in = pat;
    start_in = 1'b1;
    while (cyc < 300) begin
      @(negedge clock);
      cyc++;
      start_in = 1'b0;
      if (mem_if.enable_in) en++;
      if (mem_if.enable_in && mem_if.wb_in == 4'hF) wr++;
      if (!busy_out) gap++;
      if (done_out) begin lat = cyc; break; end
      if (inject_at > 0 && cyc == inject_at) begin
        dst_in = 32'h400; start_in = 1'b1;
      end
    end
    model_xfer(src, dst, len, fill, pat);
    exp_lat = fill ? len + 1 : 2 * len + 1;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_enables"}, 32'(en), fill ? 32'(len) : 32'(2 * len));
    check({tag, "_writes"}, 32'(wr), 32'(len));
    check({tag, "_busy_gap"}, 32'(gap), 32'd0);
    @(negedge clock);
    check({tag, "_idle_busy"}, {31'd0, busy_out}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done_out}, 32'd0);
    check_mem({tag, "_mem"});
  endtask

  task automatic reject(input string tag, input logic [31:0] src, input logic [31:0] dst,
                        input logic fill);
    src_in = src; dst_in = dst; len_in = LEN_W'(4); fill_in = fill; pattern_in = 32'h0;
    start_in = 1'b1;
    @(negedge clock);
    start_in = 1'b0;
    check({tag, "_err"}, {31'd0, err_out}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
    check({tag, "_en"}, {31'd0, mem_if.enable_in}, 32'd0);
    @(negedge clock);
    check({tag, "_err_clr"}, {31'd0, err_out}, 32'd0);
    check({tag, "_en2"}, {31'd0, mem_if.enable_in}, 32'd0);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    logic [31:0] orig;
    int          cyc, wr;
    logic        saw_done;

    reset = 1'b1; start_in = 1'b0; src_in = '0; dst_in = '0; len_in = '0;
    fill_in = 1'b0; pattern_in = '0; pa_we = 1'b0; pa_idx = '0; pa_data = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_err",  {31'd0, err_out},  32'd0);
    check("rst_en",   {31'd0, mem_if.enable_in}, 32'd0);
    check("rst_wb",   {28'd0, mem_if.wb_in}, 32'd0);
    check("rst_addr", mem_if.addr_in, 32'd0);
    check("rst_data", mem_if.data_in, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < WORDS; i++) poke(i, $urandom);

    // Directed copy
    poke(widx(32'h100), 32'h11111111);
    poke(widx(32'h104), 32'h22222222);
    poke(widx(32'h108), 32'h33333333);
    poke(widx(32'h10C), 32'h44444444);
    run_xfer("copy4", 32'h100, 32'h200, 4, 1'b0, 32'h0, 0);
    check("copy4_w0", ram[widx(32'h200)], 32'h11111111);
    check("copy4_w3", ram[widx(32'h20C)], 32'h44444444);

    // Directed fill; the word after the block must stay untouched
    orig = model[widx(32'h30C)];
    run_xfer("fill3", 32'h0, 32'h300, 3, 1'b1, 32'hDEADBEEF, 0);
    check("fill3_w2", ram[widx(32'h308)], 32'hDEADBEEF);
    check("fill3_after", ram[widx(32'h30C)], orig);

    // Zero length and rejected starts
    run_xfer("len0", 32'h100, 32'h200, 0, 1'b0, 32'h0, 0);
    reject("src_mis", 32'h102, 32'h200, 1'b0);
    reject("dst_mis", 32'h100, 32'h301, 1'b1);

    // Start while busy is ignored
    orig = model[widx(32'h400)];
    run_xfer("busy_start", 32'h100, 32'h240, 4, 1'b0, 32'h0, 3);
    check("busy_start_0x400", ram[widx(32'h400)], orig);

    // Overlapping ascending copy replicates the leading word
    orig = model[widx(32'h700)];
    run_xfer("overlap", 32'h700, 32'h704, 4, 1'b0, 32'h0, 0);
    check("overlap_last", ram[widx(32'h710)], orig);

    // Reset during the third WRITE of an 8-word copy: three words land
    src_in = 32'h500; dst_in = 32'h600; len_in = LEN_W'(8); fill_in = 1'b0;
    start_in = 1'b1;
    cyc = 0; wr = 0; saw_done = 1'b0;
    while (cyc < 100 && wr < 3) begin
      @(negedge clock);
      cyc++;
      start_in = 1'b0;
      if (done_out) saw_done = 1'b1;
      if (mem_if.enable_in && mem_if.wb_in == 4'hF) wr++;
    end
    check("rst_mid_reach_w3", 32'(wr), 32'd3);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_busy", {31'd0, busy_out}, 32'd0);
    check("rst_mid_en",   {31'd0, mem_if.enable_in}, 32'd0);
    if (done_out) saw_done = 1'b1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done_out) saw_done = 1'b1;
    end
    check("rst_mid_no_done", {31'd0, saw_done}, 32'd0);
    model_xfer(32'h500, 32'h600, 3, 1'b0, 32'h0);
    check_mem("rst_mid_mem");
    run_xfer("after_rst", 32'h0, 32'h680, 2, 1'b1, 32'hA5A5_5A5A, 0);

    // Address wrap: 12-bit RAM boundary and full 32-bit wrap
    run_xfer("wrap_ram", 32'h0, 32'hFFC, 2, 1'b1, 32'hC0FFEE00, 0);
    check("wrap_ram_w0", ram[0], 32'hC0FFEE00);
    run_xfer("wrap_32", 32'h0, 32'hFFFF_FFFC, 2, 1'b1, 32'h0BADF00D, 0);
    check("wrap_32_w0", ram[0], 32'h0BADF00D);
    run_xfer("wrap_src", 32'hFFFF_FFF8, 32'h800, 4, 1'b0, 32'h0, 0);

    // Randomized transfers
    for (int t = 0; t < 25; t++) begin
      logic [31:0] s, d, p;
      logic        f;
      int          n;
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      p = $urandom;
      f = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 12));
      run_xfer("rand", s, d, n, f, p, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
